// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. Shift-add multiplier and restoring divider, one bit per
// cycle, magnitudes only; signs are applied in a final FIX cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       begin op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV) when idle
//   a, b            rs / rt operands, sampled only at the start edge
//   hi_we, lo_we    MTHI / MTLO write strobes, wdata is the write data
//   busy            operation in flight (RUN or FIX)
//   done            one-cycle pulse after HI/LO were written by a mult/div
//   div_by_zero     qualifies done when the divisor was zero
//   hi, lo          architectural HI / LO registers
module mult_div_unit #(
    parameter int N  = 32,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    // Multiplicand (multiply) or divisor (divide), as a magnitude.
    logic [N-1:0]    opx_q, opx_d;
    // Multiply: {carry, product}, multiplier in the low half at start.
    // Divide: {unused, remainder, quotient}, dividend in the low half at start.
    logic [2*N:0]    acc_q, acc_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dbz_q, dbz_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;

    logic [N-1:0]    abs_a, abs_b;
    logic [2*N:0]    mul_tmp;
    logic [N:0]      rem_sh;
    logic [N+1:0]    trial;
    logic [2*N-1:0]  prod;

    assign abs_a = (op[0] && a[N-1]) ? -a : a;
    assign abs_b = (op[0] && b[N-1]) ? -b : b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opx_d   = opx_q;
        acc_d   = acc_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_tmp = acc_q;
        rem_sh  = acc_q[2*N-1:N-1];
        trial   = {1'b0, rem_sh} - {2'b00, opx_q};
        prod    = acc_q[2*N-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d    = op;
                    opx_d   = op[1] ? abs_b : abs_a;
                    acc_d   = {{(N+1){1'b0}}, (op[1] ? abs_a : abs_b)};
                    qneg_d  = op[0] & (a[N-1] ^ b[N-1]);
                    rneg_d  = op[0] & a[N-1];
                    dbz_d   = op[1] & (b == '0);
                    cnt_d   = CW'(N);
                    state_d = S_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    if (!trial[N+1]) begin
                        acc_d = {1'b0, trial[N-1:0], acc_q[N-2:0], 1'b1};
                    end else begin
                        acc_d = {1'b0, rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
                    end
                end else begin
                    if (acc_q[0]) begin
                        mul_tmp[2*N:N] = acc_q[2*N:N] + {1'b0, opx_q};
                    end
                    acc_d = mul_tmp >> 1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    // A zero divisor leaves |a| as remainder, so the
                    // remainder sign fix alone reproduces HI = a.
                    hi_d = rneg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
                    if (dbz_q)       lo_d = '1;
                    else if (qneg_q) lo_d = -acc_q[N-1:0];
                    else             lo_d = acc_q[N-1:0];
                end else begin
                    if (qneg_q) prod = -acc_q[2*N-1:0];
                    hi_d = prod[2*N-1:N];
                    lo_d = prod[N-1:0];
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opx_q   <= '0;
            acc_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opx_q   <= opx_d;
            acc_q   <= acc_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = (state_q == S_DONE) && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    mult_div_unit #(.N(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, mb,
                                  output logic [31:0] mhi, mlo, output logic mdbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        mdbz = 1'b0;
        mhi = '0;
        mlo = '0;
        case (mop)
            2'b00: begin p = {32'b0, ma} * {32'b0, mb}; mhi = p[63:32]; mlo = p[31:0]; end
            2'b01: begin p = 64'(sa * sb);              mhi = p[63:32]; mlo = p[31:0]; end
            default: begin
                if (mb == 0) begin
                    mdbz = 1'b1; mhi = ma; mlo = 32'hFFFF_FFFF;
                end else if (mop == 2'b10) begin
                    mlo = ma / mb; mhi = ma % mb;
                end else begin
                    q = sa / sb; r = sa % sb;
                    mlo = 32'(q); mhi = 32'(r);
                end
            end
        endcase
    endfunction

    // Called #1 after an edge: start is held for exactly one edge (E0), then
    // cycles are counted until done. Returns in the done cycle, #1 after its edge.
    task automatic do_op(input logic [1:0] top, input logic [31:0] ta, tb_,
                         output int lat, output logic [31:0] ohi, olo,
                         output logic odbz, output logic obusy, output bit stable);
        logic [31:0] h0, l0;
        start = 1'b1; op = top; a = ta; b = tb_;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        h0 = hi; l0 = lo; stable = 1'b1;
        lat = 1;
        while (!done && lat < 100) begin
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        ohi = hi; olo = lo; odbz = div_by_zero; obusy = busy;
    endtask

    task automatic idle_cycle;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 0 || lo !== 0) begin
            miscompares++;
            $display("FAIL reset: busy/done/dbz=%b hi=%h lo=%h, want 000 0 0",
                     {busy, done, div_by_zero}, hi, lo);
        end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [7] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [31:0] as  [7] = '{32'hFFFF_FFFF, -32'sd7, 32'h8000_0000, -32'sd7,
                                 32'd100, 32'd5, 32'h8000_0000};
        logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd2,
                                 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] eh  [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000,
                                 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0};
        logic [31:0] el  [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0,
                                 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        ed  [7] = '{0, 0, 0, 0, 0, 1, 0};
        int lat; logic [31:0] rh, rl; logic rd, rb; bit st;
        for (int i = 0; i < 7; i++) begin
            idle_cycle();
            do_op(ops[i], as[i], bs[i], lat, rh, rl, rd, rb, st);
            vectors++;
            if (rh !== eh[i] || rl !== el[i] || rd !== ed[i] || lat != 34 || rb !== 1'b0 || !st) begin
                miscompares++;
                $display("FAIL directed[%0d]: hi=%h lo=%h dbz=%b lat=%0d busy=%b stable=%0d, want hi=%h lo=%h dbz=%b lat=34 busy=0 stable=1",
                         i, rh, rl, rd, lat, rb, st, eh[i], el[i], ed[i]);
            end
        end
    endtask

    task automatic test_random;
        int lat; logic [31:0] rh, rl, mh, ml, ra, rb_; logic rd, md, rbz; bit st;
        logic [1:0] rop;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb_ = '0;
                1:       rb_ = $urandom_range(1, 15);
                2:       rb_ = -$urandom_range(1, 15);
                default: rb_ = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
            model(rop, ra, rb_, mh, ml, md);
            idle_cycle();
            do_op(rop, ra, rb_, lat, rh, rl, rd, rbz, st);
            vectors++;
            if (rh !== mh || rl !== ml || rd !== md || lat != 34 || !st) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dbz=%b lat=%0d stable=%0d, want hi=%h lo=%h dbz=%b lat=34",
                         i, rop, ra, rb_, rh, rl, rd, lat, st, mh, ml, md);
            end
        end
    endtask

    task automatic test_mthi_busy;
        int cyc;
        idle_cycle();
        hi_we = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1;
        hi_we = 1'b0;
        vectors++;
        if (hi !== 32'h5555) begin
            miscompares++;
            $display("FAIL mthi_idle: hi=%h, want 00005555", hi);
        end
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        vectors++;
        if (hi !== 32'h5555 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mthi_busy: hi=%h busy=%b, want 00005555 1", hi, busy);
        end
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        vectors++;
        if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd15) begin
            miscompares++;
            $display("FAIL mthi_busy_result: done=%b hi=%h lo=%h, want 1 0 0000000f", done, hi, lo);
        end
    endtask

    task automatic test_mtlo_idle;
        int cyc;
        idle_cycle();
        lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        lo_we = 1'b0;
        vectors++;
        if (lo !== 32'hABCD) begin
            miscompares++;
            $display("FAIL mtlo_idle: lo=%h, want 0000abcd", lo);
        end
        // Both strobes together in the same cycle as start: write is dropped.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd4;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        vectors++;
        if (lo !== 32'hABCD || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mt_with_start: lo=%h busy=%b, want 0000abcd 1", lo, busy);
        end
        cyc = 0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        // Both strobes in idle write HI and LO together.
        idle_cycle();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        vectors++;
        if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL mt_both: hi=%h lo=%h, want 0badf00d 0badf00d", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rh, rl, mh, ml; logic rd, md, rb; bit st;
        idle_cycle();
        do_op(2'b01, -32'sd12, 32'd5, lat, rh, rl, rd, rb, st);
        model(2'b01, -32'sd12, 32'd5, mh, ml, md);
        vectors++;
        if (rh !== mh || rl !== ml || lat != 34) begin
            miscompares++;
            $display("FAIL b2b_first: hi=%h lo=%h lat=%0d, want %h %h 34", rh, rl, lat, mh, ml);
        end
        // start issued in the DONE cycle
        do_op(2'b11, 32'd1000, -32'sd33, lat, rh, rl, rd, rb, st);
        model(2'b11, 32'd1000, -32'sd33, mh, ml, md);
        vectors++;
        if (rh !== mh || rl !== ml || lat != 34 || !st) begin
            miscompares++;
            $display("FAIL b2b_second: hi=%h lo=%h lat=%0d stable=%0d, want %h %h 34", rh, rl, lat, st, mh, ml);
        end
    endtask

    task automatic test_rst_mid;
        int lat, pulses; logic [31:0] rh, rl, mh, ml; logic rd, md, rb; bit st;
        idle_cycle();
        start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = -32'sd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 0 || lo !== 0) begin
            miscompares++;
            $display("FAIL rst_mid: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL rst_no_done: done pulses=%0d, want 0", pulses);
        end
        do_op(2'b01, 32'h1234_5678, -32'sd99, lat, rh, rl, rd, rb, st);
        model(2'b01, 32'h1234_5678, -32'sd99, mh, ml, md);
        vectors++;
        if (rh !== mh || rl !== ml || lat != 34) begin
            miscompares++;
            $display("FAIL rst_restart: hi=%h lo=%h lat=%0d, want %h %h 34", rh, rl, lat, mh, ml);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mthi_busy();
        test_mtlo_idle();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
